// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider state encoding, divider constants and the
// ALU op indices that the EXE-stage decode uses to steer DIV/DIVU here.
package cpu_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_CNT_W   = 6;
  // Edges from the accepting edge (counted as edge 1) to the edge after which
  // div_done is high: 32 CALC steps + 1 FIX + DONE entry.
  localparam int DIV_LATENCY = 34;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  localparam int OP_DIV  = 14;
  localparam int OP_DIVU = 15;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Handshake and data bundle between the EXE stage (master) and the divider
// (slave).
//
// Handshake: an operation is accepted on the rising edge where
// div_valid & div_ready & ~div_cancel. The master keeps div_valid and the
// operands stable until that edge. div_done is a one-cycle pulse; div_quot
// and div_rem are valid in that cycle and hold until the next operation's FIX.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             div_valid;
  logic             div_signed;
  logic [WIDTH-1:0] div_src1;
  logic [WIDTH-1:0] div_src2;
  logic             div_cancel;
  logic             div_ready;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  modport master (
    output div_valid, div_signed, div_src1, div_src2, div_cancel,
    input  div_ready, div_busy, div_done, div_quot, div_rem
  );

  modport slave (
    input  div_valid, div_signed, div_src1, div_src2, div_cancel,
    output div_ready, div_busy, div_done, div_quot, div_rem
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: shift {rem, dividend} left, trial-subtract the
// divisor on WIDTH+1 bits, keep the difference when it is non-negative and
// shift the resulting quotient bit into the dividend's LSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           q_bit;

  // Shift, subtract, select; the partial remainder is always < divisor so the
  // result fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_i, dvd_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    q_bit   = ~trial[WIDTH];
    rem_o   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_o   = {dvd_i[WIDTH-2:0], q_bit};
  end
endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider beside the EXE-stage ALU. Works on
// absolute values with a fixed WIDTH-step restoring loop, then applies the
// sign fix (or the divide-by-zero forced result) in FIX.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           resetn,
  div_unit_if.slave      bus,
  output div_state_e     state_o
);
  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] src1_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             zero_q;
  logic [WIDTH-1:0] quot_out_q;
  logic [WIDTH-1:0] rem_out_q;

  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;

  // Operand sign and magnitude; DIVU passes the raw values through.
  always_comb begin
    sign1 = bus.div_signed & bus.div_src1[WIDTH-1];
    sign2 = bus.div_signed & bus.div_src2[WIDTH-1];
    abs1  = sign1 ? (~bus.div_src1 + 1'b1) : bus.div_src1;
    abs2  = sign2 ? (~bus.div_src2 + 1'b1) : bus.div_src2;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .dvd_o (dvd_d)
  );

  // Main FSM: accept, iterate, sign-fix, pulse done. Cancel beats start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      src1_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
    end else if (bus.div_cancel) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          if (bus.div_valid) begin
            rem_q      <= '0;
            dvd_q      <= abs1;
            dvs_q      <= abs2;
            src1_q     <= bus.div_src1;
            neg_quot_q <= sign1 ^ sign2;
            neg_rem_q  <= sign1;
            zero_q     <= (bus.div_src2 == '0);
            cnt_q      <= '0;
            state_q    <= DIV_CALC;
          end else begin
            state_q <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= DIV_FIX;
        end
        DIV_FIX: begin
          // Divide by zero skips the sign fix: all-ones quotient and the
          // dividend exactly as presented.
          if (zero_q) begin
            quot_out_q <= '1;
            rem_out_q  <= src1_q;
          end else begin
            quot_out_q <= neg_quot_q ? (~dvd_q + 1'b1) : dvd_q;
            rem_out_q  <= neg_rem_q  ? (~rem_q + 1'b1) : rem_q;
          end
          state_q <= DIV_DONE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign bus.div_ready = (state_q == DIV_IDLE) || (state_q == DIV_DONE);
  assign bus.div_busy  = (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign bus.div_done  = (state_q == DIV_DONE);
  assign bus.div_quot  = quot_out_q;
  assign bus.div_rem   = rem_out_q;
  assign state_o       = state_q;
endmodule
